// File: rtl/wide_add_sequencer.sv
// Multi-word add/sub sequencer: streams WORDS x N-bit words through
// one shared block-lookahead adder, LSW first, with valid/ready.
module fast_adder #(
  parameter int BLOCKCOUNT  = 8,
  parameter int BITPERBLOCK = 4,
  parameter int N           = BLOCKCOUNT * BITPERBLOCK
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N-1:0] g;
  logic [N-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Block carries come from group generate/propagate; bits
  // inside a block ripple from the block carry-in.
  always_comb begin
    logic c;
    logic rc;
    logic bg;
    logic bp;
    int   idx;
    s = '0;
    c = ci;
    for (int i = 0; i < BLOCKCOUNT; i++) begin
      bg = 1'b0;
      bp = 1'b1;
      rc = c;
      for (int j = 0; j < BITPERBLOCK; j++) begin
        idx    = i * BITPERBLOCK + j;
        s[idx] = p[idx] ^ rc;
        rc     = g[idx] | (p[idx] & rc);
        bg     = g[idx] | (p[idx] & bg);
        bp     = bp & p[idx];
      end
      c = bg | (bp & c);
    end
    co = c;
  end

endmodule

module wide_add_sequencer #(
  parameter int N           = 32,
  parameter int BLOCKCOUNT  = 8,
  parameter int BITPERBLOCK = 4,
  parameter int WORDS       = 4,
  parameter int W           = WORDS * N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_s,
  output logic         o_c,
  output logic         o_v,
  output logic         o_busy
);

  if (N != BLOCKCOUNT * BITPERBLOCK) begin : g_bad_n
    $fatal(1, "wide_add_sequencer: N must equal BLOCKCOUNT*BITPERBLOCK");
  end
  if (WORDS < 1) begin : g_bad_words
    $fatal(1, "wide_add_sequencer: WORDS must be >= 1");
  end

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  s_q, s_d;
  logic          c_q, c_d;
  logic          v_q, v_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  a_word;
  logic [N-1:0]  b_word;
  logic [N-1:0]  sum;
  logic          co;
  logic          last;
  logic          accept;

  assign a_word = a_q[k_q*N +: N];
  assign b_word = b_q[k_q*N +: N] ^ {N{sub_q}};
  assign last   = (k_q == KW'(WORDS - 1));
  assign accept = (state_q == IDLE) & i_valid;

  fast_adder #(
    .BLOCKCOUNT (BLOCKCOUNT),
    .BITPERBLOCK(BITPERBLOCK),
    .N          (N)
  ) u_add (
    .a (a_word),
    .b (b_word),
    .ci(carry_q),
    .s (sum),
    .co(co)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == IDLE);
    o_busy  = (state_q != IDLE);
    o_valid = valid_q;
    o_s     = s_q;
    o_c     = c_q;
    o_v     = v_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    k_d     = k_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    valid_d = valid_q;
    if (accept) begin
      a_d     = i_a;
      b_d     = i_b;
      sub_d   = i_sub;
      carry_d = i_sub;
      k_d     = '0;
    end
    if (state_q == RUN) begin
      s_d[k_q*N +: N] = sum;
      carry_d         = co;
      k_d             = last ? '0 : k_q + KW'(1);
      if (last) begin
        c_d     = co;
        v_d     = (a_word[N-1] == b_word[N-1]) &
                  (sum[N-1] != a_word[N-1]);
        valid_d = 1'b1;
      end
    end
    if ((state_q == DONE) && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (WORDS=4, N=32):
// driver queues expected results, monitor checks on o_valid rise.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 128;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_s;
  logic         o_c;
  logic         o_v;
  logic         o_busy;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  wide_add_sequencer #(
    .N(32), .BLOCKCOUNT(8), .BITPERBLOCK(4), .WORDS(WORDS)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_sub  (i_sub),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_s    (o_s),
    .o_c    (o_c),
    .o_v    (o_v),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: one pop per rising o_valid.
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid && !pv) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h want none", o_s);
        end else begin
          e = q.pop_front();
          chk("sum", o_s, e.s);
          chk("carry", W'(o_c), W'(e.c));
          chk("ovf", W'(o_v), W'(e.v));
          chk("latency", W'(cyc - e.acc - 1), W'(WORDS));
        end
      end
      pv = o_valid;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input bit push,
                       input logic [W-1:0] es, input logic ec,
                       input logic ev);
    int   n;
    exp_t e;
    @(negedge clk);
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 want ready=1");
    end else begin
      e.s = es;
      e.c = ec;
      e.v = ev;
      e.acc = cyc;
      if (push) q.push_back(e);
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got valid=0 want valid=1");
    end
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] maxp;
    logic [W-1:0] minn;
    int           n;
    ones = '1;
    maxp = {1'b0, {(W-1){1'b1}}};
    minn = {1'b1, {(W-1){1'b0}}};
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_sub   = 1'b0;
    i_ready = 1'b1;
    #12;
    chk("rst_ready", W'(o_ready), W'(1));
    chk("rst_valid", W'(o_valid), W'(0));
    chk("rst_busy", W'(o_busy), W'(0));
    chk("rst_s", o_s, '0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1,
          128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
    issue(ones, 128'h1, 1'b0, 1, '0, 1'b1, 1'b0);
    issue(128'd5, 128'd7, 1'b1, 1,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue(128'd7, 128'd5, 1'b1, 1, 128'd2, 1'b1, 1'b0);
    issue(maxp, 128'h1, 1'b0, 1, minn, 1'b0, 1'b1);
    issue(minn, 128'h1, 1'b1, 1, maxp, 1'b1, 1'b1);

    // Backpressure in DONE with a competing request on the input.
    issue(128'd100, 128'd23, 1'b0, 1, 128'd123, 1'b0, 1'b0);
    i_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_a     = 128'd1;
      i_b     = 128'd1;
      i_sub   = 1'b0;
      #1;
      chk("bp_valid", W'(o_valid), W'(1));
      chk("bp_s", o_s, 128'd123);
      chk("bp_c", W'(o_c), W'(0));
      chk("bp_ready", W'(o_ready), W'(0));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", W'(o_valid), W'(0));
    chk("bp_release_ready", W'(o_ready), W'(1));
    issue(128'h0000_0000_0000_0001_0000_0000_0000_0000, 128'h1, 1'b1, 1,
          128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

    // Reset in the middle of RUN discards the result.
    issue(ones, ones, 1'b0, 0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", W'(o_valid), W'(0));
    chk("mid_rst_s", o_s, '0);
    chk("mid_rst_busy", W'(o_busy), W'(0));
    chk("mid_rst_ready", W'(o_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    issue(128'd3, 128'd4, 1'b0, 1, 128'd7, 1'b0, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
